// File: rtl/clkdiv_period_meter_pkg.sv
// rtl/clkdiv_period_meter_pkg.sv - shared types and default sizing for the divided-clock period meter
package clkdiv_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_LOCK_N      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int CNT_MAX         = 2**DEF_CNT_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } state_e;

    // Match counter must hold 0..LOCK_N inclusive.
    function automatic int match_w(input int lock_n);
        return (lock_n < 1) ? 1 : $clog2(lock_n + 1);
    endfunction

endpackage

// File: rtl/clkdiv_period_meter_if.sv
// rtl/clkdiv_period_meter_if.sv - divided-clock input and measurement result bundle
interface clkdiv_period_meter_if
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             i_div_clk;
    logic             o_valid;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high;
    logic             o_lock;
    logic             o_stuck;

    modport master (
        input  i_div_clk,
        output o_valid,
        output o_period,
        output o_high,
        output o_lock,
        output o_stuck
    );

    modport slave (
        output i_div_clk,
        input  o_valid,
        input  o_period,
        input  o_high,
        input  o_lock,
        input  o_stuck
    );

endinterface

// File: rtl/clkdiv_period_meter_sync_edge.sv
// rtl/clkdiv_period_meter_sync_edge.sv - input synchronizer with registered rise/fall pulses
module clkdiv_sync_edge
    import clkdiv_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
            dly_q  <= sync_lvl;
            o_rise <= sync_lvl & ~dly_q;
            o_fall <= ~sync_lvl & dly_q;
        end
    end

endmodule

// File: rtl/clkdiv_period_meter.sv
// rtl/clkdiv_period_meter.sv - measures divided-clock period and high time in source-clock cycles
// and reports lock and stuck status.
module clkdiv_period_meter
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_N      = DEF_LOCK_N,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input logic                   i_clk,
    input logic                   i_rst,
    clkdiv_period_meter_if.master meas
);

    localparam int               MW         = match_w(LOCK_N);
    localparam logic [MW-1:0]    MATCH_FULL = MW'(LOCK_N);
    localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic             hi_run_q, hi_run_d;
    logic [MW-1:0]    match_q, match_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             lock_q, lock_d;
    logic             stuck_q, stuck_d;

    logic             rise;
    logic             fall;
    logic             per_sat;
    logic             same_meas;

    clkdiv_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (meas.i_div_clk),
        .o_rise (rise),
        .o_fall (fall)
    );

    assign per_sat   = (per_cnt_q == CNT_SAT);
    assign same_meas = (per_cnt_q == period_q) && (hi_lat_q == high_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            hi_lat_q  <= '0;
            hi_run_q  <= 1'b0;
            match_q   <= '0;
            valid_q   <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            lock_q    <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            hi_lat_q  <= hi_lat_d;
            hi_run_q  <= hi_run_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            period_q  <= period_d;
            high_q    <= high_d;
            lock_q    <= lock_d;
            stuck_q   <= stuck_d;
        end
    end

    // A rise always wins over saturation, so a period of exactly CNT_SAT is still reported.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEAS;
                end else if (per_sat) begin
                    state_d = STUCK;
                end
            end
            MEAS: begin
                if (!rise && per_sat) begin
                    state_d = STUCK;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d = MEAS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        hi_lat_d  = hi_lat_q;
        hi_run_d  = hi_run_q;
        match_d   = match_q;
        valid_d   = 1'b0;
        period_d  = period_q;
        high_d    = high_q;
        lock_d    = lock_q;
        stuck_d   = stuck_q;

        if (rise) begin
            // Only a rise inside MEAS closes a full period; from IDLE/STUCK it just starts one.
            if (state_q == MEAS) begin
                valid_d  = 1'b1;
                period_d = per_cnt_q;
                high_d   = hi_lat_q;
                if ((match_q != '0) && same_meas) begin
                    match_d = (match_q == MATCH_FULL) ? MATCH_FULL : match_q + MATCH_ONE;
                end else begin
                    match_d = MATCH_ONE;
                end
                lock_d = (match_d == MATCH_FULL);
            end
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            hi_run_d  = 1'b1;
            stuck_d   = 1'b0;
        end else if (state_q != STUCK) begin
            if (per_sat) begin
                stuck_d   = 1'b1;
                lock_d    = 1'b0;
                match_d   = '0;
                per_cnt_d = '0;
                hi_cnt_d  = '0;
                hi_lat_d  = '0;
                hi_run_d  = 1'b0;
            end else begin
                per_cnt_d = per_cnt_q + CNT_ONE;
                if (state_q == MEAS) begin
                    if (hi_run_q) begin
                        hi_cnt_d = hi_cnt_q + CNT_ONE;
                    end
                    if (fall) begin
                        hi_run_d = 1'b0;
                        hi_lat_d = hi_cnt_q;
                    end
                end
            end
        end
    end

    assign meas.o_valid  = valid_q;
    assign meas.o_period = period_q;
    assign meas.o_high   = high_q;
    assign meas.o_lock   = lock_q;
    assign meas.o_stuck  = stuck_q;

endmodule
